// File: rtl/i2c_slave_responder.sv
// Single-address I2C slave endpoint: ACKs its own address, queues master writes in an
// RX FIFO and answers master reads from a preloaded TX FIFO. SCL is never stretched.

module i2c_slave_responder_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] push_data,
    input  logic             push,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    // Extra pointer bit distinguishes full from empty when the indices coincide.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= push_data;
    end
endmodule

module i2c_slave_responder #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    TX_DEPTH   = 16,
    parameter int                    RX_DEPTH   = 16,
    parameter logic [DATA_WIDTH-1:0] IDLE_BYTE  = 8'hFF
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  scl_i,
    input  logic                  sda_i,
    output logic                  sda_o,
    input  logic [6:0]            slave_addr,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_push,
    output logic                  tx_full,
    output logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_pop,
    output logic                  rx_empty,
    output logic [DATA_WIDTH-1:0] most_recent_xfer,
    output logic                  busy
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_WR_DATA,
        S_WR_ACK,
        S_RD_DATA,
        S_RD_ACK,
        S_IGNORE
    } state_t;

    state_t                state, state_nxt;
    logic [3:0]            bit_cnt, bit_cnt_nxt;
    logic [DATA_WIDTH-1:0] shift, shift_nxt;
    logic [DATA_WIDTH-1:0] tx_byte, tx_byte_nxt;
    logic                  rw, rw_nxt;
    logic                  ack_ok, ack_ok_nxt;
    logic                  sda_nxt;
    logic                  busy_nxt;
    logic [DATA_WIDTH-1:0] mrx_nxt;

    logic scl_p0, scl_p1, scl_p2;
    logic sda_p0, sda_p1, sda_p2;
    logic scl_rise, scl_fall, start_det, stop_det;

    logic                  rx_push, rx_full;
    logic                  tx_pop, tx_empty;
    logic [DATA_WIDTH-1:0] tx_head;
    logic [DATA_WIDTH-1:0] tx_next;
    logic [DATA_WIDTH-1:0] rx_byte;
    logic [2:0]            tx_idx;

    // p0/p1 form the synchronizer; p2 holds the previous synchronized level for edge detect.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            scl_p0 <= 1'b1;
            scl_p1 <= 1'b1;
            scl_p2 <= 1'b1;
            sda_p0 <= 1'b1;
            sda_p1 <= 1'b1;
            sda_p2 <= 1'b1;
        end else begin
            scl_p0 <= scl_i;
            scl_p1 <= scl_p0;
            scl_p2 <= scl_p1;
            sda_p0 <= sda_i;
            sda_p1 <= sda_p0;
            sda_p2 <= sda_p1;
        end
    end

    assign scl_rise  = scl_p1 && !scl_p2;
    assign scl_fall  = !scl_p1 && scl_p2;
    assign start_det = scl_p1 && scl_p2 && sda_p2 && !sda_p1;
    assign stop_det  = scl_p1 && scl_p2 && !sda_p2 && sda_p1;

    assign rx_byte = {shift[DATA_WIDTH-2:0], sda_p1};
    assign tx_next = tx_empty ? IDLE_BYTE : tx_head;
    assign tx_idx  = 3'd7 - bit_cnt[2:0];

    i2c_slave_responder_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk       (clk_i),
        .rst_n     (rst_i),
        .push_data (tx_data),
        .push      (tx_push),
        .pop       (tx_pop),
        .head      (tx_head),
        .full      (tx_full),
        .empty     (tx_empty)
    );

    i2c_slave_responder_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk       (clk_i),
        .rst_n     (rst_i),
        .push_data (rx_byte),
        .push      (rx_push),
        .pop       (rx_pop),
        .head      (rx_data),
        .full      (rx_full),
        .empty     (rx_empty)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state            <= S_IDLE;
            bit_cnt          <= '0;
            rw               <= 1'b0;
            ack_ok           <= 1'b0;
            sda_o            <= 1'b1;
            busy             <= 1'b0;
            most_recent_xfer <= '0;
        end else begin
            state            <= state_nxt;
            bit_cnt          <= bit_cnt_nxt;
            rw               <= rw_nxt;
            ack_ok           <= ack_ok_nxt;
            sda_o            <= sda_nxt;
            busy             <= busy_nxt;
            most_recent_xfer <= mrx_nxt;
        end
    end

    always_ff @(posedge clk_i) begin
        shift   <= shift_nxt;
        tx_byte <= tx_byte_nxt;
    end

    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        shift_nxt   = shift;
        tx_byte_nxt = tx_byte;
        rw_nxt      = rw;
        ack_ok_nxt  = ack_ok;
        sda_nxt     = sda_o;
        busy_nxt    = busy;
        mrx_nxt     = most_recent_xfer;
        rx_push     = 1'b0;
        tx_pop      = 1'b0;

        // Bus conditions outrank any SCL edge seen on the same clock.
        if (start_det) begin
            state_nxt   = S_ADDR;
            bit_cnt_nxt = '0;
            sda_nxt     = 1'b1;
        end else if (stop_det) begin
            state_nxt = S_IDLE;
            sda_nxt   = 1'b1;
            busy_nxt  = 1'b0;
        end else begin
            case (state)
                S_ADDR: begin
                    if (scl_rise && bit_cnt < 4'd8) begin
                        shift_nxt   = rx_byte;
                        bit_cnt_nxt = bit_cnt + 4'd1;
                    end else if (scl_fall && bit_cnt == 4'd8) begin
                        if (shift[DATA_WIDTH-1:1] == slave_addr) begin
                            sda_nxt   = 1'b0;
                            busy_nxt  = 1'b1;
                            rw_nxt    = shift[0];
                            state_nxt = S_ADDR_ACK;
                        end else begin
                            state_nxt = S_IGNORE;
                        end
                    end
                end
                S_ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!rw) begin
                            sda_nxt     = 1'b1;
                            bit_cnt_nxt = '0;
                            state_nxt   = S_WR_DATA;
                        end else begin
                            tx_byte_nxt = tx_next;
                            tx_pop      = !tx_empty;
                            sda_nxt     = tx_next[DATA_WIDTH-1];
                            bit_cnt_nxt = 4'd1;
                            state_nxt   = S_RD_DATA;
                        end
                    end
                end
                S_WR_DATA: begin
                    if (scl_rise && bit_cnt < 4'd8) begin
                        shift_nxt   = rx_byte;
                        bit_cnt_nxt = bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            ack_ok_nxt = !rx_full;
                            if (!rx_full) begin
                                rx_push = 1'b1;
                                mrx_nxt = rx_byte;
                            end
                        end
                    end else if (scl_fall && bit_cnt == 4'd8) begin
                        sda_nxt   = !ack_ok;
                        state_nxt = S_WR_ACK;
                    end
                end
                S_WR_ACK: begin
                    if (scl_fall) begin
                        sda_nxt     = 1'b1;
                        bit_cnt_nxt = '0;
                        state_nxt   = S_WR_DATA;
                    end
                end
                S_RD_DATA: begin
                    // bit_cnt counts bits already placed on the bus.
                    if (scl_fall) begin
                        if (bit_cnt < 4'd8) begin
                            sda_nxt     = tx_byte[tx_idx];
                            bit_cnt_nxt = bit_cnt + 4'd1;
                        end else begin
                            sda_nxt   = 1'b1;
                            mrx_nxt   = tx_byte;
                            state_nxt = S_RD_ACK;
                        end
                    end
                end
                S_RD_ACK: begin
                    if (scl_rise) begin
                        if (sda_p1) state_nxt = S_IGNORE;
                    end else if (scl_fall) begin
                        tx_byte_nxt = tx_next;
                        tx_pop      = !tx_empty;
                        sda_nxt     = tx_next[DATA_WIDTH-1];
                        bit_cnt_nxt = 4'd1;
                        state_nxt   = S_RD_DATA;
                    end
                end
                default: begin
                    sda_nxt = 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_slave_responder.sv
// Bench for i2c_slave_responder: bit-banged I2C master on an open-drain bus, checked
// against a queue-based model of the slave's FIFOs and last-transfer register.

module tb_i2c_slave_responder;
    localparam int Q   = 6;
    localparam int TXD = 16;
    localparam int RXD = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       scl;
    logic       sda_m;
    logic       tx_push;
    logic       rx_pop;
    logic [6:0] slave_addr;
    logic [7:0] tx_data;
    logic [7:0] rx_data;
    logic [7:0] mrx;
    logic       sda_o;
    logic       tx_full;
    logic       rx_empty;
    logic       busy;
    wire        sda_line;

    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    logic [7:0] m_mrx;
    logic       m_busy;
    int         checks = 0;
    int         errors = 0;

    assign sda_line = sda_m & sda_o;
    always #5 clk = ~clk;

    i2c_slave_responder #(
        .DATA_WIDTH (8),
        .TX_DEPTH   (TXD),
        .RX_DEPTH   (RXD),
        .IDLE_BYTE  (8'hFF)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst_n),
        .scl_i            (scl),
        .sda_i            (sda_line),
        .sda_o            (sda_o),
        .slave_addr       (slave_addr),
        .tx_data          (tx_data),
        .tx_push          (tx_push),
        .tx_full          (tx_full),
        .rx_data          (rx_data),
        .rx_pop           (rx_pop),
        .rx_empty         (rx_empty),
        .most_recent_xfer (mrx),
        .busy             (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bit_cyc(input logic b, output logic s);
        sda_m = b;
        tick(Q);
        scl = 1'b1;
        tick(Q);
        s = sda_line;
        tick(Q);
        scl = 1'b0;
        tick(Q);
    endtask

    task automatic start_cond();
        sda_m = 1'b1;
        tick(Q);
        scl = 1'b1;
        tick(Q);
        sda_m = 1'b0;
        tick(Q);
        scl = 1'b0;
        tick(Q);
    endtask

    task automatic stop_cond();
        sda_m = 1'b0;
        tick(Q);
        scl = 1'b1;
        tick(Q);
        sda_m = 1'b1;
        tick(Q);
        m_busy = 1'b0;
        chk("busy_after_stop", busy, m_busy);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_cyc(b[i], s);
        bit_cyc(1'b1, s);
        ack = ~s;
    endtask

    task automatic recv_byte(input logic ack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bit_cyc(1'b1, s);
            d[i] = s;
        end
        bit_cyc(~ack, s);
    endtask

    task automatic addr_phase(input logic [6:0] a, input logic rd, output logic matched);
        logic ack;
        send_byte({a, rd}, ack);
        matched = (a == slave_addr);
        if (matched) m_busy = 1'b1;
        chk("addr_ack", ack, matched);
        chk("busy_after_addr", busy, m_busy);
    endtask

    task automatic wr_byte(input logic [7:0] b);
        logic ack;
        logic exp_ack;
        send_byte(b, ack);
        exp_ack = (rx_q.size() < RXD);
        if (exp_ack) begin
            rx_q.push_back(b);
            m_mrx = b;
        end
        chk("wr_ack", ack, exp_ack);
        chk("mrx_after_wr", mrx, m_mrx);
    endtask

    task automatic rd_byte(input logic last);
        logic [7:0] got;
        logic [7:0] exp;
        exp = 8'hFF;
        if (tx_q.size() > 0) exp = tx_q.pop_front();
        recv_byte(!last, got);
        m_mrx = exp;
        chk("rd_data", got, exp);
        chk("mrx_after_rd", mrx, m_mrx);
    endtask

    task automatic host_push(input logic [7:0] b);
        chk("tx_full", tx_full, tx_q.size() == TXD);
        tx_data = b;
        tx_push = 1'b1;
        tick(1);
        tx_push = 1'b0;
        if (tx_q.size() < TXD) tx_q.push_back(b);
    endtask

    task automatic host_pop();
        chk("rx_empty", rx_empty, rx_q.size() == 0);
        if (rx_q.size() > 0) chk("rx_data", rx_data, rx_q[0]);
        rx_pop = 1'b1;
        tick(1);
        rx_pop = 1'b0;
        if (rx_q.size() > 0) void'(rx_q.pop_front());
    endtask

    initial begin
        logic       m;
        logic       s;
        logic       rd;
        logic [6:0] a;
        logic [7:0] abyte;
        int         n;

        rst_n      = 1'b0;
        scl        = 1'b1;
        sda_m      = 1'b1;
        tx_push    = 1'b0;
        rx_pop     = 1'b0;
        tx_data    = 8'h00;
        slave_addr = 7'h12;
        m_mrx      = 8'h00;
        m_busy     = 1'b0;
        tick(3);
        chk("rst_sda", sda_o, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rx_empty", rx_empty, 1'b1);
        chk("rst_tx_full", tx_full, 1'b0);
        chk("rst_mrx", mrx, 8'h00);
        rst_n = 1'b1;
        tick(4);

        // Addressed write of 0..7.
        start_cond();
        addr_phase(7'h12, 1'b0, m);
        for (int i = 0; i < 8; i++) wr_byte(8'(i));
        stop_cond();
        chk("mrx_write_seq", mrx, 8'h07);
        while (rx_q.size() > 0) host_pop();
        chk("rx_drained", rx_empty, 1'b1);

        // Read of preloaded 8..15, NACK on the last.
        for (int i = 8; i < 16; i++) host_push(8'(i));
        start_cond();
        addr_phase(7'h12, 1'b1, m);
        for (int i = 0; i < 8; i++) rd_byte(i == 7);
        stop_cond();
        chk("mrx_read_seq", mrx, 8'h0F);

        // Foreign address leaves everything untouched.
        start_cond();
        addr_phase(7'h13, 1'b0, m);
        stop_cond();
        chk("mismatch_rx_empty", rx_empty, 1'b1);

        // Write, repeated START, one-byte read, repeated eight times.
        for (int i = 0; i < 8; i++) host_push(8'($urandom));
        for (int i = 0; i < 8; i++) begin
            start_cond();
            addr_phase(7'h12, 1'b0, m);
            wr_byte(8'h03);
            start_cond();
            addr_phase(7'h12, 1'b1, m);
            rd_byte(1'b1);
            stop_cond();
        end
        while (rx_q.size() > 0) host_pop();

        // Reads with TX empty return the idle byte.
        start_cond();
        addr_phase(7'h12, 1'b1, m);
        rd_byte(1'b0);
        rd_byte(1'b1);
        stop_cond();

        // Seventeen writes without pops: the last one is refused.
        start_cond();
        addr_phase(7'h12, 1'b0, m);
        for (int i = 0; i < 17; i++) wr_byte(8'($urandom));
        stop_cond();
        for (int i = 0; i < 17; i++) host_pop();

        // TX overfill then a long read that runs past the stored bytes.
        for (int i = 0; i < 17; i++) host_push(8'($urandom));
        start_cond();
        addr_phase(7'h12, 1'b1, m);
        for (int i = 0; i < 17; i++) rd_byte(i == 16);
        stop_cond();

        // Randomized transactions with changing own address and host FIFO traffic.
        for (int it = 0; it < 10; it++) begin
            slave_addr = 7'($urandom_range(0, 127));
            repeat ($urandom_range(0, 3)) host_push(8'($urandom));
            repeat ($urandom_range(0, 2)) host_pop();
            a = slave_addr;
            if ($urandom_range(0, 3) == 0) a = slave_addr ^ 7'($urandom_range(1, 127));
            rd = 1'($urandom_range(0, 1));
            start_cond();
            addr_phase(a, rd, m);
            if (m) begin
                n = $urandom_range(1, 4);
                for (int i = 0; i < n; i++) begin
                    if (rd) rd_byte(i == n - 1);
                    else    wr_byte(8'($urandom));
                end
            end
            stop_cond();
        end
        while (rx_q.size() > 0) host_pop();
        chk("mrx_after_random", mrx, m_mrx);

        // Reset while the slave holds the address ACK low.
        slave_addr = 7'h12;
        abyte = {7'h12, 1'b0};
        start_cond();
        for (int i = 7; i >= 0; i--) bit_cyc(abyte[i], s);
        sda_m = 1'b1;
        tick(Q);
        chk("ack_driven", sda_o, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_ack_sda", sda_o, 1'b1);
        chk("rst_mid_ack_busy", busy, 1'b0);
        tick(2);
        rst_n = 1'b1;
        tx_q.delete();
        rx_q.delete();
        m_mrx  = 8'h00;
        m_busy = 1'b0;
        tick(2);
        chk("rst_mid_ack_mrx", mrx, 8'h00);
        chk("rst_mid_ack_rx_empty", rx_empty, 1'b1);
        stop_cond();

        // Fresh transfer after the reset.
        start_cond();
        addr_phase(7'h12, 1'b0, m);
        wr_byte(8'h5A);
        wr_byte(8'hC3);
        stop_cond();
        while (rx_q.size() > 0) host_pop();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/i2c_slave_responder.md
Name: i2c_slave_responder

Overview:
Synthesizable single-address I2C slave endpoint that sits on one SDA/SCL bus segment of the multi-bus I2C master controller. It ACKs its configured 7-bit address, stores bytes the master writes into an RX FIFO, and returns bytes from a preloaded TX FIFO on master reads. It also reports the most recently transferred byte for transfer logging.

Parameters:
DATA_WIDTH, 8, byte width; fixed at 8 for I2C.
TX_DEPTH, 16, TX FIFO entries; power of 2.
RX_DEPTH, 16, RX FIFO entries; power of 2.
IDLE_BYTE, 8'hFF, byte transmitted when TX FIFO is empty.

Ports:
clk_i  in  1  system clock; all logic on rising edge.
rst_i  in  1  asynchronous, active-low reset.
scl_i  in  1  bus SCL level.
sda_i  in  1  bus SDA level.
sda_o  out  1  open-drain SDA control: 0 = pull low, 1 = release (externally pulled up).
slave_addr  in  7  own address; sampled only at the address byte.
tx_data  in  8  byte to queue for master reads.
tx_push  in  1  pushes tx_data when TX FIFO is not full; ignored when full.
tx_full  out  1  TX FIFO full.
rx_data  out  8  head of RX FIFO (first-word-fall-through).
rx_pop  in  1  pops RX head when not empty; ignored when empty.
rx_empty  out  1  RX FIFO empty.
most_recent_xfer  out  8  last byte fully received or transmitted.
busy  out  1  high from an addressed START until STOP.

Behaviour:
- Reset (rst_i=0, async): sda_o=1, state IDLE, both FIFOs empty, most_recent_xfer=0, busy=0. A reset mid-transfer releases SDA immediately.
- scl_i and sda_i pass through 2-flop synchronizers. Edges are detected on the synchronized values, so input-to-action latency is 3 clk.
- START: SDA falls while SCL is high. Also a repeated START. Accepted in any state; goes to ADDR with bit counter cleared.
- STOP: SDA rises while SCL is high. Goes to IDLE, sda_o=1, busy=0.
- Bits are sampled on SCL rising. sda_o changes only on SCL falling. MSB first.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits, 7 address bits then R/W.
    - After the 8th bit, if the address matches slave_addr: next SCL fall drive sda_o=0 (ACK), busy=1, go to ADDR_ACK.
    - On mismatch: keep sda_o=1 (NACK) and go to IGNORE.
  - ADDR_ACK: on the SCL fall ending the 9th clock:
    - R/W=0: release SDA, go to WR_DATA.
    - R/W=1: load the TX head (or IDLE_BYTE if empty), pop it, drive bit7, go to RD_DATA.
  - WR_DATA: shift 8 bits.
    - If RX is not full: push the byte, update most_recent_xfer, ACK on the following fall, go to WR_ACK.
    - If RX is full: drop the byte and NACK.
  - WR_ACK: release SDA on the 9th fall, return to WR_DATA.
  - RD_DATA: drive the remaining bits on successive falls. After the 8th-bit fall, release SDA, update most_recent_xfer, go to RD_ACK.
  - RD_ACK: sample master ACK on the 9th rise.
    - SDA=0: on the fall, load the next byte and continue RD_DATA.
    - SDA=1 (NACK): go to IGNORE with SDA released.
  - IGNORE: SDA released; wait for START or STOP.
- A START or STOP detected on the same clk as an SCL edge takes priority over that edge.
- FIFOs: circular pointers with wrap at DEPTH. A simultaneous push and pop on a non-empty, non-full FIFO keeps the count unchanged. A same-cycle bus push and rx_pop on an empty RX FIFO: the push wins.
- The slave never stretches SCL.

Test Plan:
- slave_addr=0x12; START, addr byte 0x24 (write), data 0x00..0x07, STOP → 9 ACKs; RX pops 0..7 in order; most_recent_xfer=0x07; busy back to 0.
- TX preloaded 0x08..0x0F; START, 0x25, master reads 8 bytes (ACK ×7, NACK last), STOP → master receives 8..15; TX empty; most_recent_xfer=0x0F.
- START, addr 0x26 (mismatch) → SDA high at 9th clock; no FIFO change; busy stays 0.
- Alternating: START, 0x24, write 0x03, repeated START, 0x25, read 1 byte with NACK, STOP, repeated ×8 → every repeated START re-enters ADDR; reads return the next TX bytes.
- Read with TX empty → 0xFF returned; 17 writes with RX_DEPTH=16 and no pops → 17th data byte NACKed.
- Assert rst_i low while the slave drives an ACK → sda_o=1 within the same cycle; subsequent START restarts cleanly.
